// File: rtl/rc_cmd_pkg.sv
// +----------------------------------------------------------------------+
// | rc_cmd_pkg - shared constants, command codes and FSM state type      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package rc_cmd_pkg;

  localparam logic [7:0] HDR        = 8'hA5;

  localparam logic [7:0] CMD_MOTOR  = 8'h01;
  localparam logic [7:0] CMD_SERVO  = 8'h02;
  localparam logic [7:0] CMD_STOP   = 8'h03;
  localparam logic [7:0] CMD_CENTER = 8'h04;

  // {MotorA, MotorB}
  localparam logic [1:0] DIR_COAST  = 2'b00;
  localparam logic [1:0] DIR_FWD    = 2'b10;
  localparam logic [1:0] DIR_REV    = 2'b01;
  localparam logic [1:0] DIR_BRAKE  = 2'b11;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_GOT_HDR = 3'd1,
    ST_GOT_CMD = 3'd2,
    ST_GOT_DHI = 3'd3,
    ST_GOT_DLO = 3'd4
  } rx_state_e;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                           input logic [7:0] dhi,
                                           input logic [7:0] dlo);
    return cmd ^ dhi ^ dlo;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rc_timeout_timer.sv
// +----------------------------------------------------------------------+
// | rc_timeout_timer - loadable saturating down-counter, expired at zero |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rc_timeout_timer #(
  parameter longint CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic expired_o
);

  localparam int W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(CYCLES);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/rc_cmd_decoder.sv
// +----------------------------------------------------------------------+
// | rc_cmd_decoder - framed UART command decoder driving motor/servo PWM |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rc_cmd_decoder
  import rc_cmd_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int LINK_TIMEOUT_MS = 500,
  parameter int BYTE_TIMEOUT_MS = 5,
  parameter int MOTOR_MAX       = 5000,
  parameter int SERVO_MIN       = 500,
  parameter int SERVO_MAX       = 2500,
  parameter int SERVO_CENTER    = 1500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [15:0] motor_duty,
  output logic [1:0]  motor_dir,
  output logic [15:0] servo_duty,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        link_alive
);

  localparam longint c_BYTE_CYCLES = (longint'(BYTE_TIMEOUT_MS) * longint'(CLK_HZ)) / 64'sd1000;
  localparam longint c_LINK_CYCLES = (longint'(LINK_TIMEOUT_MS) * longint'(CLK_HZ)) / 64'sd1000;

  localparam logic [16:0] c_MOTOR_MAX17  = 17'(MOTOR_MAX);
  localparam logic [15:0] c_MOTOR_MAX16  = 16'(MOTOR_MAX);
  localparam logic [15:0] c_SERVO_MIN    = 16'(SERVO_MIN);
  localparam logic [15:0] c_SERVO_MAX    = 16'(SERVO_MAX);
  localparam logic [15:0] c_SERVO_CENTER = 16'(SERVO_CENTER);

  rx_state_e   state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  dhi_q, dhi_d;
  logic [7:0]  dlo_q, dlo_d;
  logic [7:0]  chk_q, chk_d;
  logic        pend_q, pend_d;
  logic [15:0] motor_duty_q, motor_duty_d;
  logic [1:0]  motor_dir_q, motor_dir_d;
  logic [15:0] servo_duty_q, servo_duty_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic        link_alive_q, link_alive_d;

  logic        w_byte_expired;
  logic        w_link_expired;
  logic [16:0] w_d_ext;
  logic [16:0] w_mag;
  logic [15:0] w_d_u;
  logic [15:0] w_motor_duty;
  logic [1:0]  w_motor_dir;
  logic [15:0] w_servo_duty;

  rc_timeout_timer #(
    .CYCLES (c_BYTE_CYCLES)
  ) u_byte_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (rx_valid),
    .expired_o (w_byte_expired)
  );

  rc_timeout_timer #(
    .CYCLES (c_LINK_CYCLES)
  ) u_link_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (frame_ok_d),
    .expired_o (w_link_expired)
  );

  // Sign-extended to 17 bits so that |-32768| is representable before clamping.
  always_comb begin
    w_d_ext = {dhi_q[7], dhi_q, dlo_q};
    w_d_u   = {dhi_q, dlo_q};
    w_mag   = w_d_ext[16] ? (17'd0 - w_d_ext) : w_d_ext;

    if (w_d_ext == '0) begin
      w_motor_duty = '0;
      w_motor_dir  = DIR_COAST;
    end else begin
      w_motor_duty = (w_mag > c_MOTOR_MAX17) ? c_MOTOR_MAX16 : w_mag[15:0];
      w_motor_dir  = w_d_ext[16] ? DIR_REV : DIR_FWD;
    end

    if (w_d_u < c_SERVO_MIN) begin
      w_servo_duty = c_SERVO_MIN;
    end else if (w_d_u > c_SERVO_MAX) begin
      w_servo_duty = c_SERVO_MAX;
    end else begin
      w_servo_duty = w_d_u;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    dhi_d        = dhi_q;
    dlo_d        = dlo_q;
    chk_d        = chk_q;
    pend_d       = 1'b0;
    motor_duty_d = motor_duty_q;
    motor_dir_d  = motor_dir_q;
    servo_duty_d = servo_duty_q;
    link_alive_d = link_alive_q;
    frame_ok_d   = 1'b0;
    frame_err_d  = 1'b0;

    if (rx_valid) begin
      unique case (state_q)
        ST_HUNT:    if (rx_data == HDR) state_d = ST_GOT_HDR;
        ST_GOT_HDR: begin cmd_d = rx_data; state_d = ST_GOT_CMD; end
        ST_GOT_CMD: begin dhi_d = rx_data; state_d = ST_GOT_DHI; end
        ST_GOT_DHI: begin dlo_d = rx_data; state_d = ST_GOT_DLO; end
        ST_GOT_DLO: begin chk_d = rx_data; pend_d = 1'b1; state_d = ST_HUNT; end
        default:    state_d = ST_HUNT;
      endcase
    end else if ((state_q != ST_HUNT) && w_byte_expired) begin
      frame_err_d = 1'b1;
      state_d     = ST_HUNT;
    end

    // The completed frame is executed one cycle after its checksum byte.
    if (pend_q) begin
      if (chk_q != frame_chk(cmd_q, dhi_q, dlo_q)) begin
        frame_err_d = 1'b1;
      end else begin
        unique case (cmd_q)
          CMD_MOTOR: begin
            frame_ok_d   = 1'b1;
            motor_duty_d = w_motor_duty;
            motor_dir_d  = w_motor_dir;
          end
          CMD_SERVO: begin
            frame_ok_d   = 1'b1;
            servo_duty_d = w_servo_duty;
          end
          CMD_STOP: begin
            frame_ok_d   = 1'b1;
            motor_duty_d = '0;
            motor_dir_d  = DIR_BRAKE;
          end
          CMD_CENTER: begin
            frame_ok_d   = 1'b1;
            servo_duty_d = c_SERVO_CENTER;
          end
          default: frame_err_d = 1'b1;
        endcase
      end
    end

    // A frame executed in the expiry cycle keeps the link alive.
    if (frame_ok_d) begin
      link_alive_d = 1'b1;
    end else if (w_link_expired) begin
      link_alive_d = 1'b0;
      motor_duty_d = '0;
      motor_dir_d  = DIR_COAST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      cmd_q        <= '0;
      dhi_q        <= '0;
      dlo_q        <= '0;
      chk_q        <= '0;
      pend_q       <= 1'b0;
      motor_duty_q <= '0;
      motor_dir_q  <= DIR_COAST;
      servo_duty_q <= c_SERVO_CENTER;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      link_alive_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      dhi_q        <= dhi_d;
      dlo_q        <= dlo_d;
      chk_q        <= chk_d;
      pend_q       <= pend_d;
      motor_duty_q <= motor_duty_d;
      motor_dir_q  <= motor_dir_d;
      servo_duty_q <= servo_duty_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      link_alive_q <= link_alive_d;
    end
  end

  assign motor_duty = motor_duty_q;
  assign motor_dir  = motor_dir_q;
  assign servo_duty = servo_duty_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign link_alive = link_alive_q;

endmodule

`default_nettype wire

// File: tb/tb_rc_cmd_decoder.sv
// +----------------------------------------------------------------------+
// | tb_rc_cmd_decoder - directed + random frames vs. behavioural model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rc_cmd_decoder;

  localparam int CLK_HZ   = 10000;
  localparam int LINK_MS  = 500;
  localparam int BYTE_MS  = 5;
  localparam int LINK_CYC = LINK_MS * CLK_HZ / 1000;
  localparam int BYTE_CYC = BYTE_MS * CLK_HZ / 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] motor_duty;
  logic [1:0]  motor_dir;
  logic [15:0] servo_duty;
  logic        frame_ok;
  logic        frame_err;
  logic        link_alive;

  int tests = 0;
  int fails = 0;

  // Behavioural model of the externally visible registers
  int m_motor, m_dir, m_servo, m_alive;

  rc_cmd_decoder #(
    .CLK_HZ          (CLK_HZ),
    .LINK_TIMEOUT_MS (LINK_MS),
    .BYTE_TIMEOUT_MS (BYTE_MS),
    .MOTOR_MAX       (5000),
    .SERVO_MIN       (500),
    .SERVO_MAX       (2500),
    .SERVO_CENTER    (1500)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .motor_duty (motor_duty),
    .motor_dir  (motor_dir),
    .servo_duty (servo_duty),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .link_alive (link_alive)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_motor = 0; m_dir = 0; m_servo = 1500; m_alive = 0;
  endtask

  function automatic logic [7:0] chk_of(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
    return c ^ h ^ l;
  endfunction

  // Returns 1 when the frame is accepted; updates the model accordingly.
  function automatic bit model_apply(input logic [7:0] c, input logic [7:0] h,
                                     input logic [7:0] l, input logic [7:0] k);
    int du, ds, mag;
    du = int'(h) * 256 + int'(l);
    ds = (du >= 32768) ? du - 65536 : du;
    if (k !== chk_of(c, h, l)) return 1'b0;
    case (int'(c))
      1: begin
        mag = (ds < 0) ? -ds : ds;
        m_motor = (mag > 5000) ? 5000 : mag;
        m_dir   = (ds > 0) ? 2 : (ds < 0) ? 1 : 0;
      end
      2: m_servo = (du < 500) ? 500 : (du > 2500) ? 2500 : du;
      3: begin m_motor = 0; m_dir = 3; end
      4: m_servo = 1500;
      default: return 1'b0;
    endcase
    m_alive = 1;
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".motor_duty"}, 32'(motor_duty), 32'(m_motor));
    check({tag, ".motor_dir"},  32'(motor_dir),  32'(m_dir));
    check({tag, ".servo_duty"}, 32'(servo_duty), 32'(m_servo));
    check({tag, ".link_alive"}, 32'(link_alive), 32'(m_alive));
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] k, input string tag);
    bit ok;
    send_byte(8'hA5); idle($urandom_range(0, 3));
    send_byte(c);     idle($urandom_range(0, 3));
    send_byte(h);     idle($urandom_range(0, 3));
    send_byte(l);     idle($urandom_range(0, 3));
    send_byte(k);
    check({tag, ".no_early_pulse"}, 32'(frame_ok | frame_err), 32'd0);
    ok = model_apply(c, h, l, k);
    @(negedge clk);
    check({tag, ".frame_ok"},  32'(frame_ok),  32'(ok));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(!ok));
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] c, h, l, k;
    logic [15:0] d;
    logic [15:0] edges [12];
    int t;
    bit seen_ok, seen_err;

    edges = '{16'h0000, 16'h8000, 16'h7FFF, 16'd5000, 16'd5001, 16'hEC78,
              16'hEC77, 16'hFFFF, 16'd500, 16'd499, 16'd2500, 16'd2501};

    model_reset();
    idle(3);
    check("reset.frame_ok",  32'(frame_ok),  32'd0);
    check("reset.frame_err", 32'(frame_err), 32'd0);
    check_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    send_frame(8'h01, 8'h0B, 8'hB8, chk_of(8'h01, 8'h0B, 8'hB8), "motor_p3000");
    @(negedge clk);
    check("motor_p3000.pulse_one_cycle", 32'(frame_ok), 32'd0);
    send_frame(8'h01, 8'h80, 8'h00, 8'h81, "motor_m32768");
    send_frame(8'h02, 8'h00, 8'h64, 8'h66, "servo_100");
    send_frame(8'h02, 8'h0F, 8'hA0, 8'hAD, "servo_4000");
    send_frame(8'h01, 8'h0B, 8'hB8, 8'h00, "bad_chk");
    send_frame(8'h07, 8'h00, 8'h00, 8'h07, "unknown_cmd");

    send_byte(8'h12);
    send_byte(8'h34);
    send_frame(8'h02, 8'hA5, 8'hDC, chk_of(8'h02, 8'hA5, 8'hDC), "noise_payload_a5");

    // Partial frame followed by silence
    send_byte(8'hA5);
    send_byte(8'h01);
    t = 0; seen_ok = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (frame_ok) seen_ok = 1'b1;
      if (frame_err) begin t = i; break; end
    end
    check("byte_timeout.fired", 32'(t > 0), 32'd1);
    check("byte_timeout.window", 32'(t >= BYTE_CYC - 3 && t <= BYTE_CYC + 4), 32'd1);
    check("byte_timeout.no_ok", 32'(seen_ok), 32'd0);
    check_outputs("byte_timeout");
    send_frame(8'h04, 8'h00, 8'h00, 8'h04, "center_after_timeout");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 8) c = 8'($urandom_range(5, 255));
      else c = 8'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 0) d = edges[$urandom_range(0, 11)];
      else d = 16'($urandom);
      h = d[15:8];
      l = d[7:0];
      k = chk_of(c, h, l);
      if ($urandom_range(0, 7) == 0) k = k ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 164)));
      send_frame(c, h, l, k, $sformatf("rand%0d", n));
    end

    // Link watchdog
    send_frame(8'h01, 8'h0B, 8'hB8, chk_of(8'h01, 8'h0B, 8'hB8), "wdg_arm");
    t = 0;
    for (int i = 1; i <= LINK_CYC + 1000; i++) begin
      @(negedge clk);
      if (!link_alive) begin t = i; break; end
    end
    check("wdg.expired", 32'(t > 0), 32'd1);
    check("wdg.window", 32'(t >= LINK_CYC - 5 && t <= LINK_CYC + 6), 32'd1);
    m_motor = 0; m_dir = 0; m_alive = 0;
    check_outputs("wdg_failsafe");
    send_frame(8'h03, 8'h00, 8'h00, 8'h03, "stop_rearm");

    // Asynchronous reset in the middle of a frame
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h0B);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midreset.frame_ok",  32'(frame_ok),  32'd0);
    check("midreset.frame_err", 32'(frame_err), 32'd0);
    check_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hB8);
    send_byte(8'hB3);
    seen_ok = 1'b0; seen_err = 1'b0;
    for (int i = 0; i < BYTE_CYC + 20; i++) begin
      @(negedge clk);
      if (frame_ok) seen_ok = 1'b1;
      if (frame_err) seen_err = 1'b1;
    end
    check("midreset.tail_no_ok",  32'(seen_ok),  32'd0);
    check("midreset.tail_no_err", 32'(seen_err), 32'd0);
    check_outputs("midreset_tail");
    send_frame(8'h01, 8'hFF, 8'h38, chk_of(8'h01, 8'hFF, 8'h38), "motor_m200");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
